// File: rtl/fir_stream_ctrl_if.sv
// fir_stream_ctrl_if: sample-in / result-out valid-ready streams.
// slave = controller side, master = source/sink side.
interface fir_stream_ctrl_if #(
  parameter int DW = 12,
  parameter int RW = 31
);
  logic          i_s_valid;
  logic          o_s_ready;
  logic [DW-1:0] i_s_data;
  logic          o_m_valid;
  logic          i_m_ready;
  logic [RW-1:0] o_m_data;

  modport slave (
    input  i_s_valid, i_s_data, i_m_ready,
    output o_s_ready, o_m_valid, o_m_data
  );

  modport master (
    output i_s_valid, i_s_data, i_m_ready,
    input  o_s_ready, o_m_valid, o_m_data
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequences a FIR datapath; credit-limited issue, result FIFO.
// Ports: clk/reset/enable, sif streams, FIR ce/sample/result, busy, count.
// FIR_CTRL_FLUSH_EN adds i_flush/o_m_last and the FLUSH state.
module fir_stream_ctrl #(
  parameter int DW    = 12,
  parameter int RW    = 31,
  parameter int LAT   = 1,
  parameter int DEPTH = 4,
  parameter int TAPS  = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
`ifdef FIR_CTRL_FLUSH_EN
  input  logic          i_flush,
  output logic          o_m_last,
`endif
  fir_stream_ctrl_if.slave sif,
  output logic          o_fir_ce,
  output logic [DW-1:0] o_fir_sample,
  input  logic [RW-1:0] i_fir_result,
  output logic          o_busy,
  output logic [15:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
`ifdef FIR_CTRL_FLUSH_EN
  localparam logic [1:0] FLUSH = 2'd2;
`endif

  logic [1:0]    state;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fcount;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [RW-1:0] mem [DEPTH];
  logic [LAT-1:0] vsr;

  logic credit;
  logic take;
  logic fl_issue;
  logic issue;
  logic push;
  logic pop;

  // credit covers both queued and still-in-pipe results
  assign credit = ({1'b0, fcount} + {1'b0, inflight}) < LIM;

  assign sif.o_s_ready = (state == RUN) && credit;
  assign take  = sif.i_s_valid && sif.o_s_ready;
  assign issue = take || fl_issue;
  assign push  = vsr[LAT-1];
  assign sif.o_m_valid = (fcount != '0);
  assign pop   = sif.o_m_valid && sif.i_m_ready;
  assign sif.o_m_data = sif.o_m_valid ? mem[rptr] : '0;

`ifdef FIR_CTRL_FLUSH_EN
  localparam int FW = $clog2(TAPS + 1);

  logic [FW-1:0]  fidx;
  logic           fl_final;
  logic           last_r;
  logic [LAT-1:0] lsr;
  logic           lmem [DEPTH];

  assign fl_issue = (state == FLUSH) && credit;
  assign fl_final = fl_issue && (fidx == FW'(TAPS - 1));
  assign o_m_last = sif.o_m_valid && lmem[rptr];
  assign o_busy   = (inflight != '0) || (fcount != '0)
                 || (state == FLUSH);

  // tag travels alongside ce so it meets its own result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fidx   <= '0;
      last_r <= 1'b0;
      lsr    <= '0;
    end else begin
      last_r <= fl_final;
      lsr    <= (lsr << 1) | LAT'(last_r);
      if (fl_issue)
        fidx <= fl_final ? '0 : fidx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      lmem[wptr] <= lsr[LAT-1];
  end
`else
  assign fl_issue = 1'b0;
  assign o_busy   = (inflight != '0) || (fcount != '0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
`ifdef FIR_CTRL_FLUSH_EN
          if (i_flush) state <= FLUSH;
          else
`endif
          if (i_enable) state <= RUN;
        end
        RUN: begin
`ifdef FIR_CTRL_FLUSH_EN
          if (i_flush) state <= FLUSH;
          else
`endif
          if (!i_enable) state <= IDLE;
        end
`ifdef FIR_CTRL_FLUSH_EN
        FLUSH: begin
          if (fl_final)
            state <= i_enable ? RUN : IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fir_ce     <= 1'b0;
      o_fir_sample <= '0;
      o_count      <= '0;
      vsr          <= '0;
      inflight     <= '0;
      fcount       <= '0;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      o_fir_ce <= issue;
      if (issue) begin
        o_fir_sample <= take ? sif.i_s_data : '0;
        o_count      <= o_count + 16'd1;
      end
      // clearing vsr on reset drops anything still in the FIR
      vsr      <= (vsr << 1) | LAT'(o_fir_ce);
      inflight <= inflight + CW'(issue) - CW'(push);
      fcount   <= fcount + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wptr] <= i_fir_result;
  end
endmodule
